// File: rtl/eca_cfg_loader.sv
// Configuration initiator for the erasure coding accelerator: disable, stream the bit-matrix
// into the user write port, write MReg, re-enable. Define ECA_CFG_READBACK_EN to read MReg back.
module eca_cfg_loader #(
  parameter int unsigned COMMON_REG_W  = 32,
  parameter int unsigned REGS_ADDR_W   = 8,
  parameter int unsigned BM_MEM_W      = 64,
  parameter int unsigned BM_MEM_ADDR_W = 6,
  parameter int unsigned EN_REG_ADDR   = 0,
  parameter int unsigned M_REG_ADDR    = 4,
  parameter int unsigned RB_TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [COMMON_REG_W-1:0]  cfg_m,
  input  logic [BM_MEM_ADDR_W:0]   cfg_bm_words,
  input  logic [BM_MEM_W-1:0]      s_bm_data,
  input  logic                     s_bm_valid,
  output logic                     s_bm_ready,
  output logic                     regs_wr_req,
  output logic [REGS_ADDR_W-1:0]   regs_wr_addr,
  output logic [COMMON_REG_W-1:0]  regs_wr_data,
  output logic                     regs_rd_req,
  output logic [REGS_ADDR_W-1:0]   regs_rd_addr,
  input  logic [COMMON_REG_W-1:0]  regs_rd_data,
  input  logic                     regs_rd_data_val,
  output logic                     user_bm_mem_wr_req,
  output logic [BM_MEM_ADDR_W-1:0] user_bm_mem_wr_addr,
  output logic [BM_MEM_W-1:0]      user_bm_mem_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  typedef enum logic [2:0] {
    StIdle,
    StDis,
    StLoad,
    StWrM,
    StRbReq,
    StRbWait,
    StEn,
    StFin
  } state_e;

  localparam logic [REGS_ADDR_W-1:0]   EnAddr   = REGS_ADDR_W'(EN_REG_ADDR);
  localparam logic [REGS_ADDR_W-1:0]   MAddr    = REGS_ADDR_W'(M_REG_ADDR);
  localparam logic [COMMON_REG_W-1:0]  EnOne    = COMMON_REG_W'(1);
  localparam logic [BM_MEM_ADDR_W:0]   MaxWords = {1'b1, {BM_MEM_ADDR_W{1'b0}}};
  localparam logic [BM_MEM_ADDR_W:0]   IdxOne   = {{BM_MEM_ADDR_W{1'b0}}, 1'b1};

  state_e                    state_q;
  logic [COMMON_REG_W-1:0]   m_q;
  logic [BM_MEM_ADDR_W:0]    words_q;
  // One bit wider than the address so a full-depth load reaches its count without wrapping.
  logic [BM_MEM_ADDR_W:0]    idx_q;
  logic [BM_MEM_ADDR_W:0]    idx_nxt;

  assign idx_nxt = idx_q + IdxOne;

`ifdef ECA_CFG_READBACK_EN
  localparam int unsigned       RbCntW = $clog2(RB_TIMEOUT + 1);
  localparam logic [RbCntW-1:0] RbLast = RbCntW'(RB_TIMEOUT - 1);
  localparam logic [RbCntW-1:0] RbOne  = RbCntW'(1);

  logic [RbCntW-1:0]       rb_cnt_q;
  logic                    rb_hit_q;
  logic [COMMON_REG_W-1:0] rb_data_q;
`else
  logic unused_rd;

  assign regs_rd_req  = 1'b0;
  assign regs_rd_addr = '0;
  assign unused_rd    = ^{regs_rd_data, regs_rd_data_val};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= StIdle;
      m_q                 <= '0;
      words_q             <= '0;
      idx_q               <= '0;
      s_bm_ready          <= 1'b0;
      regs_wr_req         <= 1'b0;
      regs_wr_addr        <= '0;
      regs_wr_data        <= '0;
      user_bm_mem_wr_req  <= 1'b0;
      user_bm_mem_wr_addr <= '0;
      user_bm_mem_wr_data <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
`ifdef ECA_CFG_READBACK_EN
      regs_rd_req         <= 1'b0;
      regs_rd_addr        <= '0;
      rb_cnt_q            <= '0;
      rb_hit_q            <= 1'b0;
      rb_data_q           <= '0;
`endif
    end else begin
      // Strobes and status pulses last one cycle unless re-armed below.
      regs_wr_req        <= 1'b0;
      user_bm_mem_wr_req <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
`ifdef ECA_CFG_READBACK_EN
      regs_rd_req        <= 1'b0;
`endif
      if (state_q != StIdle && abort) begin
        state_q    <= StIdle;
        s_bm_ready <= 1'b0;
        busy       <= 1'b0;
        err        <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              if (cfg_bm_words > MaxWords) begin
                err <= 1'b1;
              end else begin
                m_q          <= cfg_m;
                words_q      <= cfg_bm_words;
                idx_q        <= '0;
                regs_wr_req  <= 1'b1;
                regs_wr_addr <= EnAddr;
                regs_wr_data <= '0;
                busy         <= 1'b1;
                state_q      <= StDis;
              end
            end
          end

          StDis: begin
            if (words_q == '0) begin
              regs_wr_req  <= 1'b1;
              regs_wr_addr <= MAddr;
              regs_wr_data <= m_q;
              state_q      <= StWrM;
            end else begin
              s_bm_ready <= 1'b1;
              state_q    <= StLoad;
            end
          end

          StLoad: begin
            if (s_bm_valid && s_bm_ready) begin
              user_bm_mem_wr_req  <= 1'b1;
              user_bm_mem_wr_addr <= idx_q[BM_MEM_ADDR_W-1:0];
              user_bm_mem_wr_data <= s_bm_data;
              idx_q               <= idx_nxt;
              if (idx_nxt == words_q) begin
                s_bm_ready   <= 1'b0;
                regs_wr_req  <= 1'b1;
                regs_wr_addr <= MAddr;
                regs_wr_data <= m_q;
                state_q      <= StWrM;
              end
            end
          end

`ifdef ECA_CFG_READBACK_EN
          StWrM: begin
            regs_rd_req  <= 1'b1;
            regs_rd_addr <= MAddr;
            rb_cnt_q     <= '0;
            rb_hit_q     <= 1'b0;
            state_q      <= StRbReq;
          end

          StRbReq: state_q <= StRbWait;

          StRbWait: begin
            // Read data is captured first and compared the following cycle.
            if (rb_hit_q) begin
              if (rb_data_q == m_q) begin
                regs_wr_req  <= 1'b1;
                regs_wr_addr <= EnAddr;
                regs_wr_data <= EnOne;
                state_q      <= StEn;
              end else begin
                err     <= 1'b1;
                busy    <= 1'b0;
                state_q <= StIdle;
              end
            end else if (regs_rd_data_val) begin
              rb_hit_q  <= 1'b1;
              rb_data_q <= regs_rd_data;
            end else if (rb_cnt_q == RbLast) begin
              err     <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              rb_cnt_q <= rb_cnt_q + RbOne;
            end
          end
`else
          StWrM: begin
            regs_wr_req  <= 1'b1;
            regs_wr_addr <= EnAddr;
            regs_wr_data <= EnOne;
            state_q      <= StEn;
          end
`endif

          StEn: state_q <= StFin;

          StFin: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end

          default: begin
            s_bm_ready <= 1'b0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
